brick_array_ctrl: RTL
=====================

BRICK_ARRAY_CTRL -- requirements
Module: brick_array_ctrl

Interface
REQ-001 SHALL have parameter BRICKS_H, default 16, bricks per row.
REQ-002 SHALL have parameter BRICKS_V, default 8, brick rows; N = BRICKS_H*BRICKS_V, index width IW = clog2(N) (7 at defaults).
REQ-003 SHALL have parameter AUTO_FILL, default 1: 1 = start a fill automatically after reset.
REQ-004 SHALL have port visible_clk  in  1  clock, pixel clock gated by display_on.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port scan_req  in  1  display scan read request.
REQ-007 SHALL have port scan_index  in  IW  brick index to read.
REQ-008 SHALL have port scan_present  out  1  registered brick bit for the last granted scan read.
REQ-009 SHALL have port clr_req  in  1  collision clear request, one-cycle pulse.
REQ-010 SHALL have port clr_index  in  IW  brick index to clear, sampled with clr_req.
REQ-011 SHALL have port clr_busy  out  1  clear pending or in progress.
REQ-012 SHALL have port score_inc  out  1  one-cycle pulse when a present brick was cleared.
REQ-013 SHALL have port fill_start  in  1  request to refill every brick to 1.
REQ-014 SHALL have port fill_done  out  1  one-cycle pulse on completion of a fill.
REQ-015 SHALL have port bricks_left  out  IW+1  remaining brick count.
REQ-016 SHALL have port level_clear  out  1  one-cycle pulse when bricks_left reaches 0.

Function
REQ-017 SHALL model the array as single-ported: at most one read or write per cycle.
REQ-018 SHALL give scan_req absolute priority; while it is high, the FSM holds state and the counters hold value.
REQ-019 SHALL drive scan_present with array[scan_index] on the clock after a scan_req cycle, and hold it otherwise.
REQ-020 SHALL implement FSM states IDLE, CLR_RD, CLR_WR, FILL.
REQ-021 SHALL latch clr_index into a 1-deep pending register on clr_req; clr_req while the register is already full is dropped.
REQ-022 SHALL transition IDLE to CLR_RD when a clear is pending, with priority over a pending fill.
REQ-023 SHALL, in CLR_RD, read the pending index into hit and go to CLR_WR.
REQ-024 SHALL, in CLR_WR, write 0, pulse score_inc if hit=1, free the pending register, and go to IDLE.
REQ-025 SHALL latch fill_start as fill_pend in any state other than FILL; fill_start during FILL is ignored.
REQ-026 SHALL transition IDLE to FILL when fill_pend is set and no clear is pending, zeroing the fill address counter.
REQ-027 SHALL, in FILL, write 1 at the address counter each unstalled cycle; at N-1 it SHALL pulse fill_done and go to IDLE.
REQ-028 SHALL latch clr_req arriving during FILL and service it after FILL completes.
REQ-029 SHALL make clr_busy = pending register full or state in {CLR_RD, CLR_WR}.
REQ-030 SHALL give an unstalled clear a latency of 2 cycles from leaving IDLE to score_inc.

Reset
REQ-031 SHALL on reset clear all array bits, pending register, fill_pend, hit and the counters; state = IDLE; all outputs = 0.
REQ-032 SHALL set fill_pend on the first clock after reset deassertion when AUTO_FILL=1.
REQ-033 SHALL abandon a fill or clear when reset asserts mid-operation, with no partial pulses.

Configuration
REQ-034 SHALL compile the brick counter only under macro BRICK_COUNT_EN.
REQ-035 SHALL, with BRICK_COUNT_EN defined: load bricks_left = N at fill_done, decrement it on each score_inc, and pulse level_clear on the 1-to-0 transition.
REQ-036 SHALL, without BRICK_COUNT_EN, tie bricks_left and level_clear to 0.

Structure
REQ-037 SHALL place the FSM state enum and the BRICKS_H/BRICKS_V defaults in a shared package, brick_pkg.
REQ-038 SHALL implement the array plus single port as sub-module brick_ram_sp (N x 1, synchronous read and write).

Verification
REQ-039 SHALL cover: reset with AUTO_FILL=1 and no scan_req -> fill_done exactly 128 cycles after FILL entry; bricks_left=128.
REQ-040 SHALL cover: clr_req index 37 on a filled array -> score_inc 2 cycles later; scan of 37 then returns 0; bricks_left=127.
REQ-041 SHALL cover: clr_req index 37 a second time -> no score_inc; bricks_left unchanged.
REQ-042 SHALL cover: scan_req held 10 cycles during CLR_RD -> score_inc delayed by exactly 10 cycles.
REQ-043 SHALL cover: clr_req during FILL at address 50 -> fill completes first, then the clear executes; a second clr_req while clr_busy is dropped.
REQ-044 SHALL cover: 128 sequential clears -> level_clear single pulse with the last score_inc; without BRICK_COUNT_EN, level_clear stays 0.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared definitions for the brick array controller: geometry defaults and FSM state encoding.
package brick_pkg;

    localparam int BRICKS_H_DEF = 16;
    localparam int BRICKS_V_DEF = 8;

    typedef logic [1:0] brick_state_t;

    localparam brick_state_t ST_IDLE   = 2'd0;
    localparam brick_state_t ST_CLR_RD = 2'd1;
    localparam brick_state_t ST_CLR_WR = 2'd2;
    localparam brick_state_t ST_FILL   = 2'd3;

endpackage

// File: rtl/brick_ram_sp.sv
// N x 1 brick array behind a single synchronous port; reset wipes every brick.
module brick_ram_sp #(
    parameter int N  = 128,
    parameter int AW = 7
) (
    input  logic          visible_clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);

    logic [N-1:0] mem_q;
    logic         rdata_q;

    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '0;
            rdata_q <= 1'b0;
        end else if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/brick_array_ctrl.sv
// Brick array controller: display scan reads, collision clears and bulk refill sharing one port.
// Define BRICK_COUNT_EN to build the remaining-brick counter and level_clear pulse.
module brick_array_ctrl
    import brick_pkg::*;
#(
    parameter int BRICKS_H  = BRICKS_H_DEF,
    parameter int BRICKS_V  = BRICKS_V_DEF,
    parameter int AUTO_FILL = 1,
    localparam int N  = BRICKS_H * BRICKS_V,
    localparam int IW = $clog2(N)
) (
    input  logic          visible_clk,
    input  logic          reset,
    input  logic          scan_req,
    input  logic [IW-1:0] scan_index,
    output logic          scan_present,
    input  logic          clr_req,
    input  logic [IW-1:0] clr_index,
    output logic          clr_busy,
    output logic          score_inc,
    input  logic          fill_start,
    output logic          fill_done,
    output logic [IW:0]   bricks_left,
    output logic          level_clear
);

    brick_state_t  state_q, state_d;
    logic [IW-1:0] addr_q, addr_d;
    logic          pend_q;
    logic [IW-1:0] pend_idx_q;
    logic          fill_pend_q;
    logic          auto_q;
    logic          hit_q, hit;
    logic          rd_clr_q;
    logic          scan_rd_q;
    logic          scan_hold_q;

    logic          ram_en, ram_we, ram_wdata, ram_rdata;
    logic [IW-1:0] ram_addr;
    logic          clr_free, fill_go;

    // The RAM read register is shared by scans and CLR_RD, so each consumer
    // takes it only on the cycle right after its own read and holds it afterwards.
    assign hit          = rd_clr_q  ? ram_rdata : hit_q;
    assign scan_present = scan_rd_q ? ram_rdata : scan_hold_q;
    assign clr_busy     = pend_q || (state_q == ST_CLR_RD) || (state_q == ST_CLR_WR);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = pend_idx_q;
        ram_wdata = 1'b0;
        score_inc = 1'b0;
        fill_done = 1'b0;
        clr_free  = 1'b0;
        fill_go   = 1'b0;
        if (scan_req) begin
            ram_en   = 1'b1;
            ram_addr = scan_index;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        state_d = ST_CLR_RD;
                    end else if (fill_pend_q) begin
                        state_d = ST_FILL;
                        addr_d  = '0;
                        fill_go = 1'b1;
                    end
                end
                ST_CLR_RD: begin
                    ram_en  = 1'b1;
                    state_d = ST_CLR_WR;
                end
                ST_CLR_WR: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    score_inc = hit;
                    clr_free  = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_FILL: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = addr_q;
                    ram_wdata = 1'b1;
                    if (addr_q == IW'(N - 1)) begin
                        fill_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            fill_pend_q <= 1'b0;
            auto_q      <= 1'b0;
            hit_q       <= 1'b0;
            rd_clr_q    <= 1'b0;
            scan_rd_q   <= 1'b0;
            scan_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            auto_q      <= 1'b1;
            hit_q       <= hit;
            rd_clr_q    <= !scan_req && (state_q == ST_CLR_RD);
            scan_rd_q   <= scan_req;
            scan_hold_q <= scan_present;
            // A request landing while the slot is still occupied is dropped.
            if (clr_free) begin
                pend_q <= 1'b0;
            end else if (clr_req && !pend_q) begin
                pend_q     <= 1'b1;
                pend_idx_q <= clr_index;
            end
            if (fill_go)
                fill_pend_q <= 1'b0;
            else if ((fill_start && state_q != ST_FILL) || (AUTO_FILL != 0 && !auto_q))
                fill_pend_q <= 1'b1;
        end
    end

    brick_ram_sp #(.N(N), .AW(IW)) u_ram (
        .visible_clk (visible_clk),
        .reset       (reset),
        .en_i        (ram_en),
        .we_i        (ram_we),
        .addr_i      (ram_addr),
        .wdata_i     (ram_wdata),
        .rdata_o     (ram_rdata)
    );

`ifdef BRICK_COUNT_EN
    logic [IW:0] left_q;

    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset)                          left_q <= '0;
        else if (fill_done)                 left_q <= (IW+1)'(N);
        else if (score_inc && left_q != '0) left_q <= left_q - 1'b1;
    end

    assign bricks_left = left_q;
    assign level_clear = score_inc && (left_q == (IW+1)'(1));
`else
    assign bricks_left = '0;
    assign level_clear = 1'b0;
`endif

endmodule
